// File: rtl/rv_defs_pkg.sv
// rv_defs_pkg: shared RISC-V opcode constants, nop encoding and fetch state type
package rv_defs_pkg;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;
  typedef enum logic [1:0] {IDLE, FETCH, HOLD} fetch_state_e;
  function automatic logic is_illegal(input logic [31:0] w);
    return w[1:0] != 2'b11;
  endfunction
endpackage

// File: rtl/fetch_pc.sv
// fetch_pc: program counter register with hold / +4 / word-aligned redirect mux
module fetch_pc
  import rv_defs_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        advance,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc
);
  logic [31:0] pc_q, pc_d;
  // redirect beats the sequential advance; +4 wraps naturally at 2^32
  always_comb pc_d = redirect ? (redirect_pc & 32'hFFFF_FFFC) : advance ? pc_q + 32'd4 : pc_q;
  // pc register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  assign pc = pc_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch FSM presenting memory words to decode with redirect support
module fetch_unit
  import rv_defs_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        insn_valid,
  input  logic        insn_ready,
  output logic [31:0] insn,
  output logic [6:0]  opcode,
  output logic [31:0] pc,
  output logic        illegal,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] insn_count
);
  fetch_state_e state_q, state_d;
  logic [31:0] insn_q, count_q;
  logic        illegal_q;
  logic        accept, capture;
  assign accept  = (state_q == HOLD) && insn_ready;
  assign capture = (state_q == FETCH) && imem_ready && !redirect;
  fetch_pc #(.RESET_PC(RESET_PC)) u_pc (
    .clk        (clk),
    .rst_n      (rst_n),
    .advance    (accept),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .pc         (pc)
  );
  // next-state: redirect restarts fetch from any state
  always_comb begin
    state_d = state_q;
    if (redirect) state_d = FETCH;
    else
      case (state_q)
        IDLE:    state_d = FETCH;
        FETCH:   state_d = imem_ready ? HOLD : FETCH;
        HOLD:    state_d = insn_ready ? FETCH : HOLD;
        default: state_d = IDLE;
      endcase
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  // instruction capture and accepted-instruction counter
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      insn_q    <= NOP_INSN;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      if (capture) begin
        insn_q    <= imem_rdata;
        illegal_q <= is_illegal(imem_rdata);
      end
      if (accept) count_q <= count_q + 32'd1;
    end
  assign imem_req   = state_q == FETCH;
  assign imem_addr  = pc;
  assign insn_valid = state_q == HOLD;
  assign insn       = insn_q;
  assign opcode     = insn_q[6:0];
  assign illegal    = illegal_q;
  assign insn_count = count_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        insn_valid;
  logic        insn_ready = 1'b0;
  logic [31:0] insn;
  logic [6:0]  opcode;
  logic [31:0] pc;
  logic        illegal;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] insn_count;
  int checks = 0;
  int failures = 0;
  fetch_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .insn_valid (insn_valid),
    .insn_ready (insn_ready),
    .insn       (insn),
    .opcode     (opcode),
    .pc         (pc),
    .illegal    (illegal),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .insn_count (insn_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #2 rst_n = 1'b0;
    step();
    step();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(insn_valid), 32'd0);
    chk("rst_insn", insn, 32'h0000_0013);
    chk("rst_pc", pc, 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_count", insn_count, 32'd0);
    rst_n = 1'b1;
    imem_ready = 1'b1;
    imem_rdata = 32'h0000_0033;
    insn_ready = 1'b1;
    step();
    chk("c1_req", 32'(imem_req), 32'd1);
    chk("c1_addr", imem_addr, 32'd0);
    chk("c1_valid", 32'(insn_valid), 32'd0);
    step();
    chk("c2_valid", 32'(insn_valid), 32'd1);
    chk("c2_opcode", 32'(opcode), 32'h33);
    chk("c2_pc", pc, 32'd0);
    chk("c2_req", 32'(imem_req), 32'd0);
    step();
    chk("c3_addr", imem_addr, 32'd4);
    chk("c3_req", 32'(imem_req), 32'd1);
    chk("c3_count", insn_count, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      step();
    end
    chk("acc4_count", insn_count, 32'd4);
    chk("acc4_addr", imem_addr, 32'd16);
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("wait_req", 32'(imem_req), 32'd1);
      chk("wait_addr", imem_addr, 32'd16);
      chk("wait_valid", 32'(insn_valid), 32'd0);
    end
    imem_ready = 1'b1;
    imem_rdata = 32'h0000_0013;
    insn_ready = 1'b0;
    step();
    chk("ws_valid", 32'(insn_valid), 32'd1);
    chk("ws_insn", insn, 32'h0000_0013);
    chk("ws_pc", pc, 32'd16);
    imem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_valid", 32'(insn_valid), 32'd1);
      chk("hold_insn", insn, 32'h0000_0013);
      chk("hold_opcode", 32'(opcode), 32'h13);
      chk("hold_pc", pc, 32'd16);
      chk("hold_req", 32'(imem_req), 32'd0);
      chk("hold_count", insn_count, 32'd4);
    end
    insn_ready = 1'b1;
    step();
    chk("h_rel_addr", imem_addr, 32'd20);
    chk("h_rel_count", insn_count, 32'd5);
    imem_rdata = 32'h0000_006F;
    insn_ready = 1'b0;
    step();
    chk("jal_opcode", 32'(opcode), 32'h6F);
    chk("jal_pc", pc, 32'd20);
    redirect = 1'b1;
    redirect_pc = 32'h0000_0103;
    insn_ready = 1'b1;
    step();
    chk("rd_addr", imem_addr, 32'h0000_0100);
    chk("rd_valid", 32'(insn_valid), 32'd0);
    chk("rd_req", 32'(imem_req), 32'd1);
    chk("rd_count", insn_count, 32'd6);
    redirect = 1'b0;
    imem_rdata = 32'h0000_0033;
    step();
    chk("rd_tgt_valid", 32'(insn_valid), 32'd1);
    chk("rd_tgt_pc", pc, 32'h0000_0100);
    chk("rd_tgt_insn", insn, 32'h0000_0033);
    step();
    chk("seq_addr", imem_addr, 32'h0000_0104);
    chk("seq_count", insn_count, 32'd7);
    imem_rdata = 32'hCAFE_F00F;
    redirect = 1'b1;
    redirect_pc = 32'h0000_0200;
    step();
    chk("drop_valid", 32'(insn_valid), 32'd0);
    chk("drop_insn", insn, 32'h0000_0033);
    chk("drop_addr", imem_addr, 32'h0000_0200);
    redirect = 1'b0;
    imem_rdata = 32'h0000_4501;
    insn_ready = 1'b0;
    step();
    chk("ill_valid", 32'(insn_valid), 32'd1);
    chk("ill_flag", 32'(illegal), 32'd1);
    chk("ill_opcode", 32'(opcode), 32'h01);
    chk("ill_pc", pc, 32'h0000_0200);
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    insn_ready = 1'b1;
    step();
    chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
    chk("wr_count", insn_count, 32'd8);
    redirect = 1'b0;
    imem_rdata = 32'h0000_0013;
    step();
    chk("wr_pc", pc, 32'hFFFF_FFFC);
    chk("wr_illegal", 32'(illegal), 32'd0);
    step();
    chk("wrap_addr", imem_addr, 32'd0);
    chk("wrap_count", insn_count, 32'd9);
    step();
    step();
    chk("pre_rst_addr", imem_addr, 32'd4);
    chk("pre_rst_req", 32'(imem_req), 32'd1);
    imem_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req", 32'(imem_req), 32'd0);
    chk("arst_pc", pc, 32'd0);
    chk("arst_count", insn_count, 32'd0);
    chk("arst_insn", insn, 32'h0000_0013);
    step();
    rst_n = 1'b1;
    imem_ready = 1'b1;
    imem_rdata = 32'h0000_0003;
    step();
    chk("post_rst_req", 32'(imem_req), 32'd1);
    chk("post_rst_addr", imem_addr, 32'd0);
    step();
    chk("post_rst_opcode", 32'(opcode), 32'h03);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
